// File: rtl/alu_mul_seq_if.sv
// Bus between the shift-add multiply sequencer and its neighbours.
// Carries the CPU-side request/result handshake and the ALU borrow lines.
//   start/mcand/mplr                 : request from the control unit
//   busy/done/prod_hi/prod_lo/prod_z : status and product back to it
//   seq_active/seq_alu_*/seq_cin     : sequencer drive into the ALU datapath mux
//   alu_out/alu_c                    : combinational ALU result and carry
// slave  = sequencer side, master = control unit / ALU side.
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic        busy;
  logic        done;
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic        prod_z;
  logic        seq_active;
  logic [15:0] seq_alu_a;
  logic [15:0] seq_alu_b;
  logic [2:0]  seq_alu_func;
  logic        seq_cin;
  logic [15:0] alu_out;
  logic        alu_c;

  modport slave (
    input  start, mcand, mplr, alu_out, alu_c,
    output busy, done, prod_hi, prod_lo, prod_z,
           seq_active, seq_alu_a, seq_alu_b, seq_alu_func, seq_cin
  );

  modport master (
    output start, mcand, mplr, alu_out, alu_c,
    input  busy, done, prod_hi, prod_lo, prod_z,
           seq_active, seq_alu_a, seq_alu_b, seq_alu_func, seq_cin
  );
endinterface

// File: rtl/alu_mul_seq.sv
// 16x16 unsigned shift-add multiplier that borrows the shared 16-bit ALU.
// Each of ITER iterations is an ADD cycle (hi += lo[0] ? mcand : 0) followed
// by a SHIFT cycle (the {cy,hi,lo} triple moves right one bit), so the
// latency is always 2*ITER cycles plus one DONE cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : alu_mul_seq_if.slave (request, product, ALU drive/return)
// All outputs are registered; ALU operands for the next state are computed
// on the transition into it so they line up with the state register.
module alu_mul_seq #(
  parameter int ITER = 16
) (
  input logic         clk,
  input logic         reset,
  alu_mul_seq_if.slave bus
);
  localparam int W  = 16;
  localparam int CW = $clog2(ITER);

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SHR = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t         state;
  logic [W-1:0]   mcand_r, hi, lo;
  logic           cy;
  logic [CW-1:0]  cnt;
  logic           busy_r, done_r, prod_z_r, active_r;
  logic [W-1:0]   alu_a_r, alu_b_r;
  logic [2:0]     alu_func_r;

  // Results of the current SHIFT cycle; reused for the next ADD operands
  // and for the zero flag on the way into DONE.
  logic [W-1:0]   hi_shr, lo_shr;
  assign hi_shr = {cy, bus.alu_out[W-2:0]};
  assign lo_shr = {bus.alu_c, lo[W-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mcand_r    <= '0;
      hi         <= '0;
      lo         <= '0;
      cy         <= 1'b0;
      cnt        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      prod_z_r   <= 1'b0;
      active_r   <= 1'b0;
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_func_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand_r    <= bus.mcand;
            lo         <= bus.mplr;
            hi         <= '0;
            cy         <= 1'b0;
            cnt        <= '0;
            busy_r     <= 1'b1;
            active_r   <= 1'b1;
            alu_func_r <= F_ADD;
            alu_a_r    <= bus.mplr[0] ? bus.mcand : '0;
            alu_b_r    <= '0;
            state      <= S_ADD;
          end
        end
        S_ADD: begin
          hi         <= bus.alu_out;
          cy         <= bus.alu_c;
          alu_func_r <= F_SHR;
          alu_a_r    <= '0;
          alu_b_r    <= bus.alu_out;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          // ALU shifts hi right; its carry is the bit falling into lo[15],
          // while the saved add carry refills hi[15].
          hi  <= hi_shr;
          lo  <= lo_shr;
          cy  <= 1'b0;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            done_r     <= 1'b1;
            active_r   <= 1'b0;
            prod_z_r   <= ({hi_shr, lo_shr} == '0);
            alu_func_r <= '0;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            state      <= S_DONE;
          end else begin
            // lo[1] becomes the next lo[0] after this shift.
            alu_func_r <= F_ADD;
            alu_a_r    <= lo[1] ? mcand_r : '0;
            alu_b_r    <= hi_shr;
            state      <= S_ADD;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.prod_hi      = hi;
  assign bus.prod_lo      = lo;
  assign bus.prod_z       = prod_z_r;
  assign bus.seq_active   = active_r;
  assign bus.seq_alu_a    = alu_a_r;
  assign bus.seq_alu_b    = alu_b_r;
  assign bus.seq_alu_func = alu_func_r;
  assign bus.seq_cin      = 1'b0;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a behavioural ALU feeds the sequencer, products are
// checked against plain 32-bit multiplication, and each operation's timing
// and ALU ownership are checked cycle by cycle.
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mul_seq_if bus();
  alu_mul_seq #(.ITER(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // Shared ALU model: 000 = a+b+cin, 110 = b>>1 with carry = b[0].
  logic [15:0] alu_o;
  logic        alu_cf;
  always_comb begin
    alu_o  = '0;
    alu_cf = 1'b0;
    case (bus.seq_alu_func)
      3'b000: {alu_cf, alu_o} = {1'b0, bus.seq_alu_a} + {1'b0, bus.seq_alu_b} + 17'(bus.seq_cin);
      3'b110: begin alu_o = bus.seq_alu_b >> 1; alu_cf = bus.seq_alu_b[0]; end
      default: ;
    endcase
  end
  assign bus.alu_out = alu_o;
  assign bus.alu_c   = alu_cf;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_prod = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One multiply. Starts at the next falling edge, so a call made right after
  // done lands in the first IDLE cycle (back-to-back start).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit inject, input string tag);
    int lat, nbusy, nact, bad;
    bit seen;
    logic [31:0] exp;
    exp = 32'(a) * 32'(b);
    lat = 0; nbusy = 0; nact = 0; bad = 0; seen = 0;
    @(negedge clk);
    chk({tag, "_held"}, {bus.prod_hi, bus.prod_lo}, last_prod);
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    bus.start = 1'b1; bus.mcand = a; bus.mplr = b;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (bus.busy) nbusy++;
      if (bus.seq_active) begin
        nact++;
        if (bus.seq_alu_func !== ((nact % 2 == 1) ? 3'b000 : 3'b110)) bad++;
      end else if (bus.seq_alu_a !== 16'd0 || bus.seq_alu_b !== 16'd0 || bus.seq_alu_func !== 3'd0) bad++;
      if (bus.seq_cin !== 1'b0) bad++;
      if (bus.done) seen = 1'b1;
      else if (inject && lat == 5) begin
        bus.start = 1'b1; bus.mcand = 16'h7777; bus.mplr = 16'h7777;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_busy_cycles"}, nbusy, 33);
    chk({tag, "_active_cycles"}, nact, 32);
    chk({tag, "_alu_protocol"}, bad, 0);
    chk({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, exp);
    chk({tag, "_prod_z"}, 32'(bus.prod_z), 32'(exp == 0));
    if (inject) begin
      // start during DONE must not launch another operation
      bus.start = 1'b1; bus.mcand = 16'h7777; bus.mplr = 16'h7777;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_done_start_ignored"}, {30'd0, bus.busy, bus.done}, 32'd0);
      chk({tag, "_prod_after"}, {bus.prod_hi, bus.prod_lo}, exp);
    end
    last_prod = exp;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    bit          inject;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0003, 16'h0005, 32'h0000_000F, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0};
    tbl[2] = '{16'h0000, 16'h1234, 32'h0000_0000, 1'b0};
    tbl[3] = '{16'h8000, 16'h0002, 32'h0001_0000, 1'b1};
    tbl[4] = '{16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0};
    tbl[5] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0};
    tbl[7] = '{16'h1234, 16'h0000, 32'h0000_0000, 1'b0};

    bus.start = 1'b0; bus.mcand = '0; bus.mplr = '0;
    reset = 1'b0;
    #12;
    chk("reset_ctl", {28'd0, bus.busy, bus.done, bus.seq_active, bus.prod_z}, 32'd0);
    chk("reset_prod", {bus.prod_hi, bus.prod_lo}, 32'd0);
    chk("reset_alu", {bus.seq_alu_a, bus.seq_alu_b}, 32'd0);
    chk("reset_func", {28'd0, bus.seq_alu_func, bus.seq_cin}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors, back-to-back; constants in the table are cross-checked
    // against the run's own arithmetic product.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_const", i), 32'(tbl[i].a) * 32'(tbl[i].b), tbl[i].p);
      run_op(tbl[i].a, tbl[i].b, tbl[i].inject, $sformatf("tbl%0d", i));
    end

    // Abort with reset during the 5th SHIFT (cycle 10 after the start edge).
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 16'h1234; bus.mplr = 16'h5678;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("abort_in_shift", {29'd0, bus.seq_alu_func}, 32'd6);
    #2 reset = 1'b0;
    #1;
    chk("abort_ctl", {28'd0, bus.busy, bus.done, bus.seq_active, bus.prod_z}, 32'd0);
    chk("abort_prod", {bus.prod_hi, bus.prod_lo}, 32'd0);
    chk("abort_alu", {bus.seq_alu_a, bus.seq_alu_b}, 32'd0);
    chk("abort_func", {29'd0, bus.seq_alu_func}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done || bus.busy || bus.seq_active) stray++;
      end
      chk("abort_no_done", stray, 0);
    end
    last_prod = '0;
    run_op(16'h0010, 16'h0010, 1'b0, "post_reset");
    chk("post_reset_val", {bus.prod_hi, bus.prod_lo}, 32'h0000_0100);

    // Random back-to-back operations against plain multiplication.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 3) ra = '0;
      run_op(ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
